dsp_pipe_ctrl: RTL and testbench
================================

# dsp_pipe_ctrl

Valid/ready sequencer for the DSP multiply-accumulate datapath built from `flop` register cells. It tracks one valid bit per register stage and drives per-stage clock enables, so the datapath flops capture only when their stage advances. It also tags each operation with accumulate-first and accumulate-last flags, from a wrapping operation counter, so the accumulator stage knows when to clear and when to emit. It sits between the operand source (upstream) and the accumulator/result consumer (downstream).

## Interface
- `STAGES`, 4, number of datapath register stages, ≥1
- `ACC_LEN`, 16, operations per accumulation window, ≥1
- `OCC_W`, `$clog2(STAGES+1)`, width of the occupancy count

- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `flush`  in  1  synchronous clear of all in-flight operations and of the op counter
- `in_valid`  in  1  upstream operand valid
- `in_ready`  out  1  upstream handshake; an operand is accepted when `in_valid && in_ready`
- `stage_en`  out  STAGES  capture enable for datapath stage i
- `stage_valid`  out  STAGES  stage i holds a live operation
- `out_valid`  out  1  the last stage holds a result
- `out_ready`  in  1  downstream accepts the result
- `out_acc_first`  out  1  the result at the output is the first of its window
- `out_acc_last`  out  1  the result at the output is the last of its window
- `occupancy`  out  OCC_W  number of set `stage_valid` bits
- `busy`  out  1  `occupancy != 0`

## Operation
**Registers**
- Valid bits `v[STAGES-1:0]`.
- Tag bits `f[]` (first) and `l[]` (last), moving in lockstep with `v`.
- Op counter `cnt` with range 0..ACC_LEN-1.

**Enables**
- Stage −1 is the input: its valid is `in_valid`, its first flag is `cnt==0`, its last flag is `cnt==ACC_LEN-1`.
- Stage i advances when `stage_en[i]=1`. On advance: `v[i]<=v[i-1]`, `f[i]<=f[i-1]`, `l[i]<=l[i-1]`. Otherwise all three hold.
- `in_ready = stage_en[0] && !flush`.

**Outputs and counter**
- `out_valid = v[STAGES-1]`.
- `out_acc_first = v[STAGES-1] && f[STAGES-1]`; `out_acc_last = v[STAGES-1] && l[STAGES-1]`.
- `cnt` increments on each accepted input and wraps from ACC_LEN-1 to 0.
- When ACC_LEN=1, every operation is both first and last.
- `stage_valid = v`. `occupancy` is the combinational popcount of `v`.

**Flush**
- Flush forces all `stage_en` to 0 and `in_ready` to 0.
- On the next edge, `v`, `f`, `l` and `cnt` clear to 0.
- Flush has priority over a simultaneous `in_valid` and `out_ready`. No handshake completes in a flush cycle.

## Timing
- Values during and after reset: `v`, `f`, `l` and `cnt` are 0.
  - `out_valid`, `out_acc_first`, `out_acc_last`, `occupancy` and `busy` are 0.
  - `stage_en` is all 1s and `in_ready` is 1, unless `flush` is asserted.
- Reset asserted mid-operation drops all in-flight operations immediately, asynchronously.
- Latency: an operand accepted at edge k has `out_valid` high after edge k+STAGES-1, i.e. STAGES cycles including the acceptance cycle, when there is no backpressure.
- Throughput: 1 operation per cycle while `out_ready` is high.
- Full pipe with `out_ready=0`: all valid stages hold and `in_ready=0`.
- Full pipe with `out_ready=1`: output retires, input is accepted, and occupancy is unchanged.
- Empty pipe with `in_valid=0`: enables stay high and `v` stays 0.
- `in_ready` and `stage_en` depend combinationally on `out_ready` and `flush` only. They have no path from `in_valid`.

## Configuration
`DSP_PIPE_CTRL_BUBBLE_COLLAPSE_EN`
- **Defined:** enables are per stage.
  - `stage_en[STAGES-1] = !v[STAGES-1] || out_ready`.
  - `stage_en[i] = !v[i] || stage_en[i+1]`.
  - Empty stages fill even when the output is stalled.
- **Undefined:** one global enable, `stage_en[i] = !v[STAGES-1] || out_ready` for all i.
  - A stalled output freezes the whole pipe, bubbles included.
- Both modes give the same latency and ordering when there is no backpressure.

## Structure
- **Package `dsp_pipe_pkg`** holds:
  - default constants `DSP_STAGES_DEF=4` and `DSP_ACC_LEN_DEF=16`;
  - a packed struct `pipe_tag_t {v, f, l}` for the per-stage state.
- **Sub-module `dsp_pipe_ctrl_stage`**, one per stage:
  - holds one `pipe_tag_t` register with asynchronous reset;
  - inputs are the previous stage's tag and the enable;
  - instantiated STAGES times from a generate loop.
- The top level holds enable generation, the op counter, flush and the popcount.

## Test plan
- **Single op:** STAGES=4, ACC_LEN=16, one `in_valid` pulse with `out_ready=1` → `out_valid` rises 4 cycles later with `out_acc_first=1` and `out_acc_last=0`; `occupancy` steps 1 then 0.
- **Streaming:** 32 back-to-back ops with `out_ready=1` → 32 consecutive outputs; `out_acc_first` on results 0 and 16, `out_acc_last` on results 15 and 31.
- **Stall:** fill with 4 ops, hold `out_ready=0` for 5 cycles → `in_ready=0` and `occupancy=4` held; release → 4 outputs in order.
- **Bubble collapse:** ops at cycles 0 and 2, then `out_ready=0` → with the macro defined, `occupancy` reaches 2 with `v=4'b1100`; without it, `v=4'b1010` is frozen.
- **Flush:** 3 ops in flight, `in_valid=1`, `flush=1` for one cycle → `in_ready=0` that cycle; next cycle `occupancy=0` and `cnt=0`; the next op is tagged first.
- **Mid-op reset:** assert `reset` between edges with 2 ops in flight → outputs clear without waiting for an edge; after release, `in_ready=1` and ACC_LEN=1 tagging shows first=last=1.

Source files
------------

// File: rtl/dsp_pipe_pkg.sv
// Shared constants and per-stage tag type for the DSP pipeline sequencer.
package dsp_pipe_pkg;

  localparam int DSP_STAGES_DEF  = 4;
  localparam int DSP_ACC_LEN_DEF = 16;

  typedef struct packed {
    logic v;
    logic f;
    logic l;
  } pipe_tag_t;

  // A window of one op still needs a one-bit counter so the range compare stays legal.
  function automatic int cnt_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/dsp_pipe_ctrl_stage.sv
// One pipeline stage of valid/first/last tracking; captures the upstream tag when enabled.
module dsp_pipe_ctrl_stage
  import dsp_pipe_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      clr,
  input  logic      en,
  input  pipe_tag_t tag_in,
  output pipe_tag_t tag_out
);

  pipe_tag_t tag_q;
  pipe_tag_t tag_d;

  always_comb begin
    tag_d = tag_q;
    if (clr) begin
      tag_d = '0;
    end else if (en) begin
      tag_d = tag_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tag_out = tag_q;

endmodule

// File: rtl/dsp_pipe_ctrl.sv
// Valid/ready sequencer for the DSP MAC datapath: per-stage enables, occupancy and window tags.
// Optional macro DSP_PIPE_CTRL_BUBBLE_COLLAPSE_EN selects per-stage enables that squeeze out bubbles.
module dsp_pipe_ctrl
  import dsp_pipe_pkg::*;
#(
  parameter int STAGES  = DSP_STAGES_DEF,
  parameter int ACC_LEN = DSP_ACC_LEN_DEF,
  parameter int OCC_W   = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_acc_first,
  output logic              out_acc_last,
  output logic [OCC_W-1:0]  occupancy,
  output logic              busy
);

  localparam int               CNT_W   = cnt_width(ACC_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACC_LEN - 1);

  pipe_tag_t         tag_in [STAGES];
  pipe_tag_t         tag_q  [STAGES];
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] en;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [OCC_W-1:0]  occ;
  logic              accept;

`ifdef DSP_PIPE_CTRL_BUBBLE_COLLAPSE_EN
  // A stage may move whenever any stage at or beyond it has room, or the output drains.
  logic room;

  always_comb begin
    en   = '0;
    room = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      room  = room || !v[i];
      en[i] = room;
    end
    if (flush) begin
      en = '0;
    end
  end
`else
  always_comb begin
    en = '0;
    if (!flush) begin
      en = {STAGES{!v[STAGES-1] || out_ready}};
    end
  end
`endif

  assign stage_en = en;
  assign in_ready = en[0] && !flush;
  assign accept   = in_valid && in_ready;

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_stage
      if (g == 0) begin : g_head
        assign tag_in[g] = '{v: in_valid, f: (cnt_q == '0), l: (cnt_q == CNT_MAX)};
      end else begin : g_body
        assign tag_in[g] = tag_q[g-1];
      end

      dsp_pipe_ctrl_stage u_stage (
        .clk     (clk),
        .reset   (reset),
        .clr     (flush),
        .en      (en[g]),
        .tag_in  (tag_in[g]),
        .tag_out (tag_q[g])
      );

      assign v[g] = tag_q[g].v;
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ = occ + OCC_W'(v[i]);
    end
  end

  assign stage_valid   = v;
  assign out_valid     = v[STAGES-1];
  assign out_acc_first = v[STAGES-1] && tag_q[STAGES-1].f;
  assign out_acc_last  = v[STAGES-1] && tag_q[STAGES-1].l;
  assign occupancy     = occ;
  assign busy          = (occ != '0);

endmodule

// File: tb/tb_dsp_pipe_ctrl.sv
// Self-checking bench for dsp_pipe_ctrl: op-slot model plus directed literal checks.
// Honours DSP_PIPE_CTRL_BUBBLE_COLLAPSE_EN the same way the design does.
module tb_dsp_pipe_ctrl;

  localparam int S  = 4;
  localparam int AL = 16;
  localparam int OW = $clog2(S + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic [S-1:0]  stage_en;
  logic [S-1:0]  stage_valid;
  logic          out_valid;
  logic          out_acc_first;
  logic          out_acc_last;
  logic [OW-1:0] occupancy;
  logic          busy;

  logic          a1_in_ready;
  logic [S-1:0]  a1_stage_en;
  logic [S-1:0]  a1_stage_valid;
  logic          a1_out_valid;
  logic          a1_first;
  logic          a1_last;
  logic [OW-1:0] a1_occupancy;
  logic          a1_busy;

  int checks = 0;
  int errors = 0;
  int slot [S];
  int acc_n;
  int ret_n;
  int first_q [$];
  int last_q [$];
  int lat;

  always #5 clk = ~clk;

  dsp_pipe_ctrl #(.STAGES(S), .ACC_LEN(AL)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .stage_en(stage_en), .stage_valid(stage_valid), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc_first(out_acc_first), .out_acc_last(out_acc_last),
    .occupancy(occupancy), .busy(busy)
  );

  dsp_pipe_ctrl #(.STAGES(S), .ACC_LEN(1)) dut_a1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a1_in_ready),
    .stage_en(a1_stage_en), .stage_valid(a1_stage_valid), .out_valid(a1_out_valid),
    .out_ready(out_ready), .out_acc_first(a1_first), .out_acc_last(a1_last),
    .occupancy(a1_occupancy), .busy(a1_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < S; i++) slot[i] = -1;
    acc_n = 0;
  endtask

  // Stage i may move if the output drains or some stage at or beyond i is empty.
  function automatic logic [S-1:0] modelEn();
    logic [S-1:0] e;
    e = '0;
    if (!flush) begin
      for (int i = 0; i < S; i++) begin
`ifdef DSP_PIPE_CTRL_BUBBLE_COLLAPSE_EN
        e[i] = out_ready;
        for (int j = i; j < S; j++) if (slot[j] < 0) e[i] = 1'b1;
`else
        e[i] = out_ready || (slot[S-1] < 0);
`endif
      end
    end
    return e;
  endfunction

  task automatic modelStep();
    logic [S-1:0] e;
    e = modelEn();
    if (flush) begin
      clearModel();
    end else begin
      for (int i = S - 1; i >= 1; i--) if (e[i]) slot[i] = slot[i-1];
      if (e[0]) begin
        slot[0] = in_valid ? (acc_n % AL) : -1;
        if (in_valid) acc_n++;
      end
    end
  endtask

  task automatic compareCycle();
    logic [S-1:0] e;
    logic [S-1:0] vexp;
    int occ;
    int top;
    e = modelEn();
    vexp = '0;
    occ = 0;
    for (int i = 0; i < S; i++) if (slot[i] >= 0) begin vexp[i] = 1'b1; occ++; end
    top = slot[S-1];
    checkOutput("stage_en", 32'(stage_en), 32'(e));
    checkOutput("in_ready", 32'(in_ready), 32'(e[0]));
    checkOutput("stage_valid", 32'(stage_valid), 32'(vexp));
    checkOutput("occupancy", 32'(occupancy), 32'(occ));
    checkOutput("busy", 32'(busy), 32'(occ != 0));
    checkOutput("out_valid", 32'(out_valid), 32'(top >= 0));
    checkOutput("out_acc_first", 32'(out_acc_first), 32'(top >= 0 && top % AL == 0));
    checkOutput("out_acc_last", 32'(out_acc_last), 32'(top >= 0 && top % AL == AL - 1));
    checkOutput("a1_out_valid", 32'(a1_out_valid), 32'(top >= 0));
    checkOutput("a1_first", 32'(a1_first), 32'(top >= 0));
    checkOutput("a1_last", 32'(a1_last), 32'(top >= 0));
    if (out_valid && out_ready && !flush) begin
      if (out_acc_first) first_q.push_back(ret_n);
      if (out_acc_last) last_q.push_back(ret_n);
      ret_n++;
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic ordy, input logic fl);
    @(posedge clk);
    modelStep();
    #1;
    in_valid = iv;
    out_ready = ordy;
    flush = fl;
    @(negedge clk);
    compareCycle();
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    clearModel();
    ret_n = 0;
    first_q.delete();
    last_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    clearModel();
    ret_n = 0;
    #2;
    checkOutput("rst_stage_en", 32'(stage_en), 32'hF);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    doReset();

    // Single op: output appears four cycles after the pulse, tagged first only.
    applyStimulus(1, 1, 0);
    lat = 0;
    for (int k = 0; k < 10 && !out_valid; k++) begin
      applyStimulus(0, 1, 0);
      lat++;
      if (lat == 1) checkOutput("single_occ_one", 32'(occupancy), 32'd1);
    end
    checkOutput("single_latency", 32'(lat), 32'd4);
    checkOutput("single_first", 32'(out_acc_first), 32'd1);
    checkOutput("single_last", 32'(out_acc_last), 32'd0);
    applyStimulus(0, 1, 0);
    checkOutput("single_occ_zero", 32'(occupancy), 32'd0);

    // Streaming: 32 back-to-back ops span exactly two windows.
    doReset();
    for (int k = 0; k < 32; k++) applyStimulus(1, 1, 0);
    for (int k = 0; k < 6; k++) applyStimulus(0, 1, 0);
    checkOutput("stream_count", 32'(ret_n), 32'd32);
    checkOutput("stream_nfirst", 32'(first_q.size()), 32'd2);
    checkOutput("stream_nlast", 32'(last_q.size()), 32'd2);
    if (first_q.size() == 2 && last_q.size() == 2) begin
      checkOutput("stream_first0", 32'(first_q[0]), 32'd0);
      checkOutput("stream_first1", 32'(first_q[1]), 32'd16);
      checkOutput("stream_last0", 32'(last_q[0]), 32'd15);
      checkOutput("stream_last1", 32'(last_q[1]), 32'd31);
    end

    // Stall: full pipe holds with input blocked, then drains four results.
    doReset();
    for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 0, 0);
      checkOutput("stall_occ", 32'(occupancy), 32'd4);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    end
    for (int k = 0; k < 6; k++) applyStimulus(0, 1, 0);
    checkOutput("stall_drained", 32'(ret_n), 32'd4);

    // Bubble: ops two cycles apart, then the output stalls.
    doReset();
    applyStimulus(1, 1, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0);
`ifdef DSP_PIPE_CTRL_BUBBLE_COLLAPSE_EN
    checkOutput("bubble_v", 32'(stage_valid), 32'b1100);
`else
    checkOutput("bubble_v", 32'(stage_valid), 32'b1010);
`endif
    checkOutput("bubble_occ", 32'(occupancy), 32'd2);

    // Flush: in-flight ops vanish and the counter restarts a window.
    doReset();
    for (int k = 0; k < 3; k++) applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 1);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
    checkOutput("flush_stage_en", 32'(stage_en), 32'd0);
    applyStimulus(1, 1, 0);
    checkOutput("flush_occ", 32'(occupancy), 32'd0);
    for (int k = 0; k < 10 && !out_valid; k++) applyStimulus(0, 1, 0);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd1);
    checkOutput("flush_first", 32'(out_acc_first), 32'd1);
    checkOutput("flush_last", 32'(out_acc_last), 32'd0);

    // Mid-op reset clears outputs between edges.
    doReset();
    for (int k = 0; k < 3; k++) applyStimulus(1, 1, 0);
    checkOutput("prereset_occ", 32'(occupancy), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_occ", 32'(occupancy), 32'd0);
    checkOutput("midreset_v", 32'(stage_valid), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    clearModel();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("postreset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("postreset_a1_ready", 32'(a1_in_ready), 32'd1);
    applyStimulus(1, 1, 0);
    for (int k = 0; k < 10 && !a1_out_valid; k++) applyStimulus(0, 1, 0);
    checkOutput("a1_valid_lit", 32'(a1_out_valid), 32'd1);
    checkOutput("a1_first_lit", 32'(a1_first), 32'd1);
    checkOutput("a1_last_lit", 32'(a1_last), 32'd1);
    applyStimulus(0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
